// File: rtl/mul_result_formatter.sv
// Formats the 64-bit multiplier product into a 32-bit ALU word with Z/N/V flags.
// Results are buffered in a small FIFO, and a saturating counter tracks overflowed results.
module mul_result_formatter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_res,
    input  logic             in_ovf,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are high.
    // Ready never depends on valid, and in_ready depends only on registered occupancy.

    logic [34:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [34:0]      last_q, last_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic        fits32;
    logic [31:0] fmt_data;
    logic        fmt_v;
    logic [34:0] entry;
    logic [34:0] head;
    logic        push, pop;

    always_comb begin
        fits32   = (&in_res[63:31]) | ~(|in_res[63:31]);
        fmt_data = in_res[31:0];
        fmt_v    = in_ovf | ~fits32;
        case (in_mode)
            2'b01: begin
                fmt_data = in_res[63:32];
                fmt_v    = in_ovf;
            end
            2'b10: begin
                if (fits32) begin
                    fmt_data = in_res[31:0];
                    fmt_v    = in_ovf;
                end else begin
                    fmt_data = in_res[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    fmt_v    = 1'b1;
                end
            end
            default: begin
                fmt_data = in_res[31:0];
                fmt_v    = in_ovf | ~fits32;
            end
        endcase
        // Entry layout: {V, N, Z, data}
        entry = {fmt_v, fmt_data[31], (fmt_data == 32'd0), fmt_data};
    end

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        last_d    = last_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = head;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (clr_stats) ovf_cnt_d = '0;
        else if (push && fmt_v && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_q    <= '0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            last_q    <= last_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry;
    end

    always_comb begin
        out_data = last_q[31:0];
        out_z    = last_q[32];
        out_n    = last_q[33];
        out_v    = last_q[34];
        if (out_valid) begin
            out_data = head[31:0];
            out_z    = head[32];
            out_n    = head[33];
            out_v    = head[34];
        end
    end

    assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_mul_result_formatter.sv
// Bench for mul_result_formatter: reference model of the formatting rules and FIFO order,
// compared every cycle, plus directed literal checks on the documented scenarios.
module tb_mul_result_formatter;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_res = '0;
    logic             in_ovf = 1'b0;
    logic [1:0]       in_mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic             out_z, out_n, out_v;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    mul_result_formatter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_ovf(in_ovf), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_z(out_z), .out_n(out_n), .out_v(out_v),
        .clr_stats(clr_stats), .ovf_cnt(ovf_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference formatting from the arithmetic value of the product; result is {V,N,Z,data}
    function automatic logic [34:0] fmt(input logic [63:0] r, input logic o, input logic [1:0] m);
        longint      s;
        bit          fits;
        logic [31:0] d;
        logic        v;
        s    = longint'(r);
        fits = (s >= 64'shFFFF_FFFF_8000_0000) && (s <= 64'sh0000_0000_7FFF_FFFF);
        if (m == 2'b01) begin
            d = r[63:32];
            v = o;
        end else if (m == 2'b10) begin
            if (fits) begin
                d = r[31:0];
                v = o;
            end else begin
                d = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                v = 1'b1;
            end
        end else begin
            d = r[31:0];
            v = o | !fits;
        end
        return {v, d[31], (d == 32'd0), d};
    endfunction

    // scoreboard model
    logic [34:0] exp_q[$];
    logic [34:0] last_exp = '0;
    int          cnt_exp = 0;

    always @(negedge reset) begin
        exp_q.delete();
        last_exp = '0;
        cnt_exp  = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            bit          do_pop, do_push;
            logic [34:0] e;
            do_pop  = (exp_q.size() > 0) && out_ready;
            do_push = in_valid && (exp_q.size() < DEPTH);
            e       = fmt(in_res, in_ovf, in_mode);
            if (do_pop) last_exp = exp_q.pop_front();
            if (do_push) exp_q.push_back(e);
            if (clr_stats) cnt_exp = 0;
            else if (do_push && e[34] && cnt_exp < (1 << CNT_W) - 1) cnt_exp++;
        end
    end

    // compare process: outputs depend only on registered state, so sample on the falling edge
    always @(negedge clk) begin
        logic [34:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : last_exp;
        chk("in_ready",  in_ready,  exp_q.size() < DEPTH);
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("out_data",  out_data,  e[31:0]);
        chk("out_z",     out_z,     e[32]);
        chk("out_n",     out_n,     e[33]);
        chk("out_v",     out_v,     e[34]);
        chk("ovf_cnt",   ovf_cnt,   cnt_exp);
    end

    // driver tasks: inputs change just after the falling edge
    task automatic push_one(input logic [63:0] r, input logic o, input logic [1:0] m);
        in_valid = 1'b1;
        in_res   = r;
        in_ovf   = o;
        in_mode  = m;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] rand_res();
        logic [63:0] r;
        case ($urandom_range(0, 4))
            0: r = {{32{1'b0}}, 32'($urandom)};
            1: r = 64'($signed(32'($urandom)));
            2: r = {32'($urandom), 32'($urandom)};
            3: r = ($urandom_range(0, 1) != 0) ? 64'h0000_0000_8000_0000 : 64'hFFFF_FFFF_7FFF_FFFF;
            default: r = ($urandom_range(0, 1) != 0) ? 64'h0000_0000_7FFF_FFFF : 64'hFFFF_FFFF_8000_0000;
        endcase
        return r;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_ovf_cnt", ovf_cnt, 0);
        reset = 1'b1;
        @(negedge clk);

        // -15 in LOW mode
        out_ready = 1'b1;
        push_one(64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 2'b00);
        chk("neg15_valid", out_valid, 1);
        chk("neg15_data", out_data, 32'hFFFF_FFF1);
        chk("neg15_nzv", {out_n, out_z, out_v}, 3'b100);
        chk("neg15_cnt", ovf_cnt, 0);

        // 2^32 in each mode, back to back
        push_one(64'h0000_0001_0000_0000, 1'b0, 2'b00);
        chk("low_data", out_data, 32'h0);
        chk("low_zv", {out_z, out_v}, 2'b11);
        push_one(64'h0000_0001_0000_0000, 1'b0, 2'b01);
        chk("high_data", out_data, 32'h1);
        chk("high_v", out_v, 0);
        push_one(64'h0000_0001_0000_0000, 1'b0, 2'b10);
        chk("sat_pos_data", out_data, 32'h7FFF_FFFF);
        chk("sat_pos_v", out_v, 1);
        chk("sat_cnt2", ovf_cnt, 2);

        push_one(64'hFFFF_FFFE_0000_0000, 1'b0, 2'b10);
        chk("sat_neg_data", out_data, 32'h8000_0000);
        chk("sat_neg_nv", {out_n, out_v}, 2'b11);
        push_one(64'h0000_0000_7FFF_FFFF, 1'b0, 2'b10);
        chk("sat_fit_data", out_data, 32'h7FFF_FFFF);
        chk("sat_fit_v", out_v, 0);
        idle(2);

        // backpressure: three pushes offered with the consumer stalled
        out_ready = 1'b0;
        push_one(64'd11, 1'b0, 2'b00);
        chk("bp_ready1", in_ready, 1);
        push_one(64'd22, 1'b0, 2'b00);
        chk("bp_ready2", in_ready, 0);
        in_valid = 1'b1;
        in_res   = 64'd33;
        repeat (2) @(negedge clk);
        chk("bp_held_head", out_data, 32'd11);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", out_data, 32'd22);
        chk("bp_ready_back", in_ready, 1);
        @(negedge clk);
        chk("bp_head_c", out_data, 32'd33);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // pointer wrap over steady push/pop pairs
        for (int i = 0; i < 10; i++) push_one(rand_res(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        idle(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_res    = rand_res();
            in_ovf    = ($urandom_range(0, 7) == 0);
            in_mode   = 2'($urandom_range(0, 3));
            clr_stats = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        clr_stats = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // counter saturation and clear priority
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        chk("cnt_cleared", ovf_cnt, 0);
        for (int i = 0; i < 260; i++) push_one(64'd5, 1'b1, 2'b00);
        chk("cnt_sat", ovf_cnt, 255);
        clr_stats = 1'b1;
        push_one(64'd5, 1'b1, 2'b00);
        clr_stats = 1'b0;
        chk("cnt_clr_prio", ovf_cnt, 0);
        idle(2);

        // asynchronous reset pulse between edges with a full FIFO
        out_ready = 1'b0;
        push_one(64'd7, 1'b1, 2'b00);
        push_one(64'd8, 1'b1, 2'b00);
        chk("pre_rst_full", in_ready, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_out_data", out_data, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", out_valid, 0);
        out_ready = 1'b1;
        push_one(64'h0000_0000_0000_0042, 1'b0, 2'b00);
        chk("post_rst_data", out_data, 32'h42);
        @(negedge clk);
        chk("post_rst_no_stale", out_valid, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
